// File: rtl/conv_accum_lanes.sv
// conv_accum_lanes: multi-lane windowed accumulator for the convolution datapath.
// Each lane sums TAPS signed samples into a signed ACC_WIDTH accumulator. The
// arithmetic either wraps or saturates, and a sticky overflow flag is kept per
// lane. A valid/ready handshake on each side frames one window per result.
module conv_accum_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int NUM_LANES  = 4,
    parameter int TAPS       = 9,
    parameter int SATURATE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr_in,
    input  logic                            en_in,
    input  logic                            valid_in,
    output logic                            ready_o,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    output logic                            valid_o,
    input  logic                            ready_in,
    output logic [NUM_LANES*ACC_WIDTH-1:0]  sum_o,
    output logic [NUM_LANES-1:0]            ovf_o,
    output logic [$clog2(TAPS+1)-1:0]       tap_cnt_o
);

    localparam int CNT_WIDTH = $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_LANES-1:0]   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_LANES];
    logic [ACC_WIDTH-1:0]   acc_d [NUM_LANES];

    // Per-lane candidate result and overflow indication for the current sample.
    logic [ACC_WIDTH-1:0]   lane_next [NUM_LANES];
    logic [NUM_LANES-1:0]   lane_ovf;
    logic                   accept;

    // Per-lane add: the true sum is one bit wider than the accumulator. The two
    // top bits then disagree exactly when that sum leaves the signed ACC_WIDTH range.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] sample;
        logic [ACC_WIDTH:0]    full;

        assign sample = data_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign full   = {acc_q[l][ACC_WIDTH-1], acc_q[l]}
                      + {{(ACC_WIDTH + 1 - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
        assign lane_ovf[l] = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];

        // The sign of the true sum picks the clamp bound: negative overflow
        // goes to the minimum, positive overflow to the maximum.
        assign lane_next[l] = (lane_ovf[l] && (SATURATE != 0))
                            ? (full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}})
                            : full[ACC_WIDTH-1:0];

        assign sum_o[l*ACC_WIDTH +: ACC_WIDTH] = acc_q[l];
    end

    assign ready_o   = en_in & (state_q != ST_DONE);
    assign accept    = valid_in & ready_o;
    assign valid_o   = (state_q == ST_DONE);
    assign ovf_o     = ovf_q;
    assign tap_cnt_o = cnt_q;

    // Next-state logic: clear, output handshake, or accept a sample.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;

        if (clr_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ovf_d   = '0;
            acc_d   = '{default: '0};
        end else if (en_in) begin
            if (state_q == ST_DONE) begin
                // The result is consumed, so the window empties for a one-cycle bubble.
                if (ready_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ovf_d   = '0;
                    acc_d   = '{default: '0};
                end
            end else if (accept) begin
                acc_d   = lane_next;
                ovf_d   = ovf_q | lane_ovf;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = (cnt_q == CNT_WIDTH'(TAPS - 1)) ? ST_DONE : ST_ACCUM;
            end
        end
    end

    // State, counter, flags and accumulators with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= '0;
            // NOTE: the accumulator array is plain flops, not RAM; it must reset so that sum_o reads 0 after rst.
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_conv_accum_lanes.sv
// Bench for conv_accum_lanes. Three instances share one stimulus stream:
// - the default 20-bit wrapping instance;
// - a 10-bit saturating instance;
// - a 10-bit wrapping instance.
// A behavioural model tracks every accumulator. Each completed window pushes
// its expected result to a queue, and the entry is popped when valid_o rises.
module tb_conv_accum_lanes;

    localparam int TAPS = 9;

    logic        clk = 1'b0;
    logic        rst, clr_in, en_in, valid_in, ready_in;
    logic signed [7:0] lane_v [4];
    logic [31:0] data_in;

    logic        ready0, ready1, ready2, valid0, valid1, valid2;
    logic [79:0] sum0;
    logic [39:0] sum1, sum2;
    logic [3:0]  ovf0, ovf1, ovf2, cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    // Model state: [dut][lane].
    longint macc [3][4];
    bit     movf [3][4];
    int     mcnt  = 0;
    bit     mdone = 0;
    bit     chk_en = 0;
    bit     prev_v = 0;
    longint exp_q [$];

    assign data_in = {lane_v[3], lane_v[2], lane_v[1], lane_v[0]};

    always #5 clk = ~clk;

    conv_accum_lanes u_dut0 (
        .clk(clk), .rst(rst), .clr_in(clr_in), .en_in(en_in), .valid_in(valid_in),
        .ready_o(ready0), .data_in(data_in), .valid_o(valid0), .ready_in(ready_in),
        .sum_o(sum0), .ovf_o(ovf0), .tap_cnt_o(cnt0));

    conv_accum_lanes #(.ACC_WIDTH(10), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr_in(clr_in), .en_in(en_in), .valid_in(valid_in),
        .ready_o(ready1), .data_in(data_in), .valid_o(valid1), .ready_in(ready_in),
        .sum_o(sum1), .ovf_o(ovf1), .tap_cnt_o(cnt1));

    conv_accum_lanes #(.ACC_WIDTH(10), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst(rst), .clr_in(clr_in), .en_in(en_in), .valid_in(valid_in),
        .ready_o(ready2), .data_in(data_in), .valid_o(valid2), .ready_in(ready_in),
        .sum_o(sum2), .ovf_o(ovf2), .tap_cnt_o(cnt2));

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cfg_w(input int d);
        return (d == 0) ? 20 : 10;
    endfunction

    function automatic bit cfg_sat(input int d);
        return (d == 1);
    endfunction

    function automatic longint obs_sum(input int d, input int l);
        case (d)
            0:       return longint'($signed(sum0[l*20 +: 20]));
            1:       return longint'($signed(sum1[l*10 +: 10]));
            default: return longint'($signed(sum2[l*10 +: 10]));
        endcase
    endfunction

    function automatic longint obs_ovf(input int d, input int l);
        case (d)
            0:       return longint'(ovf0[l]);
            1:       return longint'(ovf1[l]);
            default: return longint'(ovf2[l]);
        endcase
    endfunction

    function automatic longint obs_valid(input int d);
        return longint'((d == 0) ? valid0 : (d == 1) ? valid1 : valid2);
    endfunction

    function automatic longint obs_ready(input int d);
        return longint'((d == 0) ? ready0 : (d == 1) ? ready1 : ready2);
    endfunction

    function automatic longint obs_cnt(input int d);
        return longint'((d == 0) ? cnt0 : (d == 1) ? cnt1 : cnt2);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int l = 0; l < 4; l++) begin
                macc[d][l] = 0;
                movf[d][l] = 0;
            end
        mcnt  = 0;
        mdone = 0;
    endtask

    // Advance the model by one clock edge, using the inputs currently driven.
    task automatic model_step();
        if (rst || clr_in) begin
            model_clear();
        end else if (en_in) begin
            if (mdone) begin
                if (ready_in) model_clear();
            end else if (valid_in) begin
                for (int d = 0; d < 3; d++)
                    for (int l = 0; l < 4; l++) begin
                        longint t;
                        longint lo;
                        longint hi;
                        longint span;
                        span = longint'(1) << cfg_w(d);
                        lo   = -(span / 2);
                        hi   = (span / 2) - 1;
                        t    = macc[d][l] + longint'(lane_v[l]);
                        if (t < lo || t > hi) begin
                            movf[d][l] = 1;
                            if (cfg_sat(d)) begin
                                t = (t < lo) ? lo : hi;
                            end else begin
                                t = t & (span - 1);
                                if (t > hi) t = t - span;
                            end
                        end
                        macc[d][l] = t;
                    end
                mcnt++;
                if (mcnt == TAPS) begin
                    mdone = 1;
                    for (int d = 0; d < 3; d++)
                        for (int l = 0; l < 4; l++) begin
                            exp_q.push_back(macc[d][l]);
                            exp_q.push_back(longint'(movf[d][l]));
                        end
                end
            end
        end
    endtask

    // Compare live outputs against the model; when valid_o rises, also pop the window result.
    task automatic live_check();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_valid", d), obs_valid(d), longint'(mdone));
            check($sformatf("d%0d_ready", d), obs_ready(d), longint'(en_in & !mdone));
            check($sformatf("d%0d_cnt", d), obs_cnt(d), longint'(mcnt));
            for (int l = 0; l < 4; l++) begin
                check($sformatf("d%0d_sum_l%0d", d, l), obs_sum(d, l), macc[d][l]);
                check($sformatf("d%0d_ovf_l%0d", d, l), obs_ovf(d, l), longint'(movf[d][l]));
            end
        end
        if (valid0 && !prev_v) begin
            if (exp_q.size() < 24) begin
                check("sb_entries", longint'(exp_q.size()), 24);
            end else begin
                for (int d = 0; d < 3; d++)
                    for (int l = 0; l < 4; l++) begin
                        check($sformatf("win_d%0d_sum_l%0d", d, l), obs_sum(d, l), exp_q.pop_front());
                        check($sformatf("win_d%0d_ovf_l%0d", d, l), obs_ovf(d, l), exp_q.pop_front());
                    end
            end
        end
        prev_v = valid0;
    endtask

    // One clock: check at the falling edge, advance the model, then drive after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) live_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int a, input int b, input int c, input int e);
        lane_v[0] = 8'(a);
        lane_v[1] = 8'(b);
        lane_v[2] = 8'(c);
        lane_v[3] = 8'(e);
    endtask

    task automatic consume();
        valid_in = 0;
        ready_in = 1;
        tick();
        ready_in = 0;
        tick();
    endtask

    initial begin
        rst = 1; clr_in = 0; en_in = 1; valid_in = 0; ready_in = 0;
        set_lanes(0, 0, 0, 0);
        model_clear();
        tick();
        tick();
        chk_en = 1;
        rst = 0;
        tick();

        // Defaults window, then backpressure in DONE with valid_in held high.
        set_lanes(1, -1, 127, -128);
        valid_in = 1;
        repeat (TAPS) tick();
        repeat (6) tick();
        consume();

        // Lane 0 overflows the 10-bit instances; other lanes stay at zero.
        set_lanes(127, 0, 0, 0);
        valid_in = 1;
        repeat (TAPS) tick();
        valid_in = 0;
        tick();
        consume();

        // Clear after four accepts with a sample presented in the same cycle.
        set_lanes(2, 2, 2, 2);
        valid_in = 1;
        repeat (4) tick();
        clr_in = 1;
        tick();
        clr_in = 0;
        repeat (TAPS) tick();
        valid_in = 0;
        consume();

        // Enable toggling every cycle; a ready_in pulse while disabled is not consumed.
        set_lanes(3, 3, 3, 3);
        valid_in = 1;
        for (int i = 0; i < 2 * TAPS; i++) begin
            en_in = (i % 2 == 0);
            tick();
        end
        en_in = 0; ready_in = 1;
        tick();
        en_in = 1; ready_in = 0;
        tick();
        valid_in = 0;
        consume();

        // Reset in DONE, then reset midway through accumulation.
        set_lanes(5, -7, 100, -100);
        valid_in = 1;
        repeat (TAPS) tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0; en_in = 0;
        tick();
        en_in = 1; valid_in = 0;
        tick();

        // Random samples with random valid/ready gaps.
        for (int i = 0; i < 60; i++) begin
            set_lanes($urandom_range(255) - 128, $urandom_range(255) - 128,
                      $urandom_range(255) - 128, $urandom_range(255) - 128);
            valid_in = ($urandom_range(3) != 0);
            ready_in = ($urandom_range(1) != 0);
            tick();
        end
        valid_in = 0;
        ready_in = 1;
        repeat (3) tick();

        check("sb_leftover", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
